run_pattern_tx: RTL and testbench
=================================

// Module: run_pattern_tx
// PURPOSE
//  Serial stimulus transmitter for the run-of-ones falling-edge detector.
//  - On a start request, drives serial line x high for run_len cycles, then
//    low for one terminator cycle, then low for GAP_CYCLES idle cycles.
//  - The detector raises its output during the terminator cycle.
//  - Sits upstream of the detector and drives its x input; used for link
//    self-test and framing.
// PARAMETERS
//  LEN_W       4  width of run_len; run length range 1..2^LEN_W-1
//  GAP_CYCLES  1  idle low cycles after terminator (0 allowed); 0..255
// PORTS
//  clk      in   1      single clock; all logic on posedge
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      request a frame; sampled on posedge
//  run_len  in   LEN_W  number of '1' bits in the frame; sampled with start
//  x        out  1      serial output (registered)
//  busy     out  1      frame in progress; start is ignored while 1
//  term     out  1      high in the terminator cycle (x=0 after ones)
//  done     out  1      1-cycle pulse: frame complete, back in IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; x=0, busy=0, term=0, done=0.
//    Counters are cleared immediately, including mid-frame.
//  - All outputs are registered. They are functions of the state/counters
//    at each posedge.
//  - States:
//    IDLE:
//      - If start=1 and run_len!=0: latch len=run_len, go to ONES.
//      - If start=1 and run_len==0: ignored; stay in IDLE, no outputs change.
//    ONES: x=1, busy=1. Stays len cycles (down-counter), then goes to TERM.
//    TERM: x=0, busy=1, term=1 for exactly 1 cycle.
//      - Then GAP if GAP_CYCLES>0, else IDLE.
//    GAP: x=0, busy=1 for GAP_CYCLES cycles, then IDLE.
//  - done=1 for the first cycle back in IDLE (busy=0 in that cycle).
//  - Latency: start accepted at posedge N -> x=1 visible after posedge N;
//    x stays high for len cycles.
//  - Frame length = len + 1 + GAP_CYCLES cycles of busy=1.
//  - Back-to-back frames:
//    - A start in the done cycle is accepted.
//    - Minimum inter-frame spacing = 1 IDLE cycle.
//  - start while busy=1: ignored, not queued. run_len changes mid-frame have
//    no effect, because len is latched.
//  - len=2^LEN_W-1 (max): no overflow. The counter is LEN_W bits and counts
//    down to 1.
//  - No bit ever leaves x undefined; x=0 in every state except ONES.
// CONFIGURATION
//  - Macro RUN_PATTERN_TX_FCNT_EN:
//    - Defined: adds port frame_cnt (out, 16 bits).
//      - Increments in the done cycle and wraps 16'hFFFF->0.
//      - Cleared by rst_n.
//    - Undefined: the port and counter are absent; behaviour is otherwise
//      identical.
// TESTING
//  1. run_len=3, start 1 cycle -> x: 1,1,1,0,0; term high in 4th cycle;
//     busy 5 cycles; done once.
//  2. run_len=1 -> x: 1,0,0; term in 2nd cycle. With GAP_CYCLES=0: x 1,0;
//     done the next cycle.
//  3. run_len=0 with start -> busy, x, term, done stay 0 for 10 cycles.
//  4. start pulsed again during ONES with a different run_len -> ignored;
//     frame keeps the original length.
//  5. rst_n low mid-ONES (asynchronous, between edges) -> x=0, busy=0
//     immediately. After release, the next start gives a clean frame.
//  6. run_len=15 followed by start in the done cycle -> 15 ones, term,
//     gap, then a second frame without loss. With the FCNT_EN macro,
//     frame_cnt=2.

Source files
------------

// File: rtl/run_pattern_tx.sv
// run_pattern_tx: serial run-of-ones frame generator (len ones, terminator, gap idle).
// Optional RUN_PATTERN_TX_FCNT_EN adds a 16-bit completed-frame counter port.
module run_pattern_tx #(
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  output logic             x,
  output logic             busy,
  output logic             term,
  output logic             done
`ifdef RUN_PATTERN_TX_FCNT_EN
  ,output logic [15:0]     frame_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ONES, TERM, GAP} state_t;
  localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [7:0] gcnt, gcnt_nx;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    case (state)
      IDLE: if (start && run_len != '0) begin
        state_nx = ONES;
        cnt_nx   = run_len;
      end
      ONES: if (cnt == LEN_W'(1)) state_nx = TERM;
            else cnt_nx = cnt - 1'b1;
      TERM: begin
        state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
        gcnt_nx  = GAP_INIT;
      end
      GAP:  if (gcnt == 8'd1) state_nx = IDLE;
            else gcnt_nx = gcnt - 1'b1;
      default: state_nx = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they are true flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      x     <= 1'b0;
      busy  <= 1'b0;
      term  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gcnt  <= gcnt_nx;
      x     <= state_nx == ONES;
      busy  <= state_nx != IDLE;
      term  <= state_nx == TERM;
      done  <= state != IDLE && state_nx == IDLE;
    end
  end
`ifdef RUN_PATTERN_TX_FCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (state != IDLE && state_nx == IDLE) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_run_pattern_tx.sv
// tb_run_pattern_tx: drives two transmitters (gap 1 and gap 0) with directed
// frames and checks every cycle against a frame-position model.
module tb_run_pattern_tx;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [3:0] run_len = '0;
  logic x0, b0, t0, d0, x1, b1, t1, d1;
`ifdef RUN_PATTERN_TX_FCNT_EN
  logic [15:0] fc0, fc1;
`endif
  int checks = 0, errors = 0;
  int pos[2] = '{1000, 1000};
  int len_m[2] = '{0, 0};
  int mcnt[2] = '{0, 0};
  logic [15:0] xs0, bs0, ts0, ds0, xs1, bs1, ds1;
  int ones0, ones1, dn0;
  logic again;
`ifdef RUN_PATTERN_TX_FCNT_EN
  logic [15:0] fc_base;
`endif

  always #5 clk = ~clk;

  run_pattern_tx #(.LEN_W(4), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .run_len(run_len),
    .x(x0), .busy(b0), .term(t0), .done(d0)
`ifdef RUN_PATTERN_TX_FCNT_EN
    , .frame_cnt(fc0)
`endif
  );
  run_pattern_tx #(.LEN_W(4), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .run_len(run_len),
    .x(x1), .busy(b1), .term(t1), .done(d1)
`ifdef RUN_PATTERN_TX_FCNT_EN
    , .frame_cnt(fc1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int d);
    return d == 0 ? 1 : 0;
  endfunction

  // expected {x,busy,term,done} at position p within a frame of l ones and g gap cycles
  function automatic logic [3:0] expv(input int g, input int l, input int p);
    return p < l ? 4'b1100 : p == l ? 4'b0110 : p < l + 1 + g ? 4'b0100 :
           p == l + 1 + g ? 4'b0001 : 4'b0000;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] e;
      e = expv(gap_of(d), len_m[d], pos[d]);
      if (!rst_n) pos[d] = 1000;
      else if (start && run_len != 0 && !e[2]) begin
        pos[d] = 0;
        len_m[d] = int'(run_len);
      end else if (pos[d] < 1000) pos[d]++;
    end
  end

  initial forever begin
    logic [3:0] e0, e1;
    @(negedge clk);
    e0 = expv(1, len_m[0], pos[0]);
    e1 = expv(0, len_m[1], pos[1]);
    if (!rst_n) begin
      mcnt[0] = 0;
      mcnt[1] = 0;
    end
    if (e0[0]) mcnt[0]++;
    if (e1[0]) mcnt[1]++;
    chk("out_gap1", {28'd0, x0, b0, t0, d0}, {28'd0, e0});
    chk("out_gap0", {28'd0, x1, b1, t1, d1}, {28'd0, e1});
`ifdef RUN_PATTERN_TX_FCNT_EN
    chk("frame_cnt_gap1", {16'd0, fc0}, mcnt[0]);
    chk("frame_cnt_gap0", {16'd0, fc1}, mcnt[1]);
`endif
  end

  task automatic trace(input logic [3:0] l, input int n);
    xs0 = '0; bs0 = '0; ts0 = '0; ds0 = '0; xs1 = '0; bs1 = '0; ds1 = '0;
    start = 1'b1;
    run_len = l;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      xs0 = {xs0[14:0], x0}; bs0 = {bs0[14:0], b0};
      ts0 = {ts0[14:0], t0}; ds0 = {ds0[14:0], d0};
      xs1 = {xs1[14:0], x1}; bs1 = {bs1[14:0], b1}; ds1 = {ds1[14:0], d1};
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {28'd0, x0, b0, t0, d0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    trace(4'd3, 6);
    chk("t1_x", xs0, 16'b111000);
    chk("t1_term", ts0, 16'b000100);
    chk("t1_busy", bs0, 16'b111110);
    chk("t1_done", ds0, 16'b000001);
    chk("t1_busy_g0", bs1, 16'b111100);
    chk("t1_done_g0", ds1, 16'b000010);
    trace(4'd1, 4);
    chk("t2_x", xs0, 16'b1000);
    chk("t2_term", ts0, 16'b0100);
    chk("t2_busy", bs0, 16'b1110);
    chk("t2_x_g0", xs1, 16'b1000);
    chk("t2_done_g0", ds1, 16'b0010);
    trace(4'd0, 10);
    chk("t3_idle", {xs0[9:0], bs0[9:0], ts0[9:0], ds0[9:0]}, 32'd0);
    chk("t3_idle_g0", {bs1[9:0], ds1[9:0]}, 32'd0);
    start = 1'b1;
    run_len = 4'd5;
    ones0 = 0; ones1 = 0; dn0 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 2) run_len = 4'd2;
      ones0 += int'(x0); ones1 += int'(x1); dn0 += int'(d0);
    end
    start = 1'b0;
    chk("t4_ones", ones0, 5);
    chk("t4_ones_g0", ones1, 5);
    chk("t4_done", dn0, 1);
    start = 1'b1;
    run_len = 4'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_pre_x", {31'd0, x0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async", {28'd0, x0, b0, x1, b1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    trace(4'd3, 6);
    chk("t5_x_after", xs0, 16'b111000);
    chk("t5_busy_after", bs0, 16'b111110);
`ifdef RUN_PATTERN_TX_FCNT_EN
    fc_base = fc0;
`endif
    start = 1'b1;
    run_len = 4'd15;
    again = 1'b0;
    ones0 = 0; dn0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ones0 += int'(x0); dn0 += int'(d0);
      if (!again && d0) begin
        start = 1'b1;
        again = 1'b1;
      end else start = 1'b0;
    end
    chk("t6_restart", {31'd0, again}, 32'd1);
    chk("t6_ones", ones0, 30);
    chk("t6_done", dn0, 2);
`ifdef RUN_PATTERN_TX_FCNT_EN
    chk("t6_frame_cnt", {16'd0, fc0 - fc_base}, 32'd2);
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
